tnn_feature_framer: RTL and testbench
=====================================

# tnn_feature_framer

Upstream feeder for the 3-input approximate TNN neuron cores (whitewine, 3-bit-per-feature variants). It accepts a serial stream of raw unsigned feature samples with a valid/ready handshake, quantizes each one to 3 bits, and groups three consecutive samples into one frame (feature a, then b, then c). It then presents the frame as stable, registered `input_a`/`input_b`/`input_c`-compatible buses to the combinational neuron through a second valid/ready handshake. It also detects malformed frames and counts delivered and rejected frames.

## Interface
Parameters:
- `DATA_W`, default 8: raw sample width, unsigned.
- `OFFSET`, default 0: value subtracted from each raw sample before scaling.
- `SHIFT`, default 5: right-shift applied after the offset subtraction.
- `CNT_W`, default 16: width of the frame and error counters.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_data` input DATA_W: raw feature sample.
- `in_last` input 1: marks the final sample of a frame; qualified by `in_valid`.
- `in_valid` input 1: sample present.
- `in_ready` output 1: framer can accept a sample.
- `feat_a` output 3: quantized feature 0, drives neuron `input_a`.
- `feat_b` output 3: quantized feature 1, drives neuron `input_b`.
- `feat_c` output 3: quantized feature 2, drives neuron `input_c`.
- `out_valid` output 1: the feat_* outputs hold a complete frame.
- `out_ready` input 1: downstream has consumed the frame.
- `err_pulse` output 1: one-cycle pulse when a malformed frame is discarded.
- `frame_cnt` output CNT_W: number of delivered frames; wraps.
- `err_cnt` output CNT_W: number of discarded frames; saturates at all-ones.

## Operation
**Quantization** (combinational, per sample):
- `d = (in_data > OFFSET) ? in_data - OFFSET : 0`
- `q = d >> SHIFT`, then saturate: `q = (q > 7) ? 7 : q`.
- The result is always 3 bits.

**FSM states:** GET_A, GET_B, GET_C, HOLD. Reset state is GET_A. A sample is accepted when `in_valid & in_ready`.
- **GET_A:** on accept, store q in an `a_shadow` register. If `in_last`=1, the frame is short: discard it, pulse `err_pulse`, and stay in GET_A. Otherwise go to GET_B.
- **GET_B:** on accept, store q in `b_shadow`. If `in_last`=1: discard, pulse error, go to GET_A. Otherwise go to GET_C.
- **GET_C:** on accept:
  - If `in_last`=1: load `feat_a`←`a_shadow`, `feat_b`←`b_shadow`, `feat_c`←q, set `out_valid`, go to HOLD.
  - If `in_last`=0 (long frame): discard, pulse error, go to GET_A. Every following sample is then treated as the start of a new frame; no skip-to-last resynchronisation is performed.
- **HOLD:** the feat_* outputs are frozen. On `out_valid & out_ready`: clear `out_valid`, increment `frame_cnt`, go to GET_A.

**Other rules:**
- `in_ready` = 1 in GET_A, GET_B and GET_C; 0 in HOLD. There is no input/output overlap; the block is intentionally non-pipelined.
- The shadow registers are not cleared on error. Stale values are harmless because they are overwritten before use.
- `err_cnt` increments on every `err_pulse` and stops at `2^CNT_W-1`.

## Timing
- **Reset values:** `in_ready`=0 while `rst_n`=0 and 1 from the first cycle after release. `out_valid`=0, feat_* = 0, `err_pulse`=0, both counters 0, state GET_A.
- **Latency:** the third sample is accepted at edge N. `out_valid` and feat_* are valid after edge N, so the neuron output is settled in the same cycle.
- **Output stability:** feat_* change only on the GET_C→HOLD transition and never while `out_valid`=1.
- **Frame release:** a frame is released at the edge where `out_valid & out_ready`. The next sample can be accepted at the following edge. Throughput is at best one frame per 4 cycles.
- **Error pulse:** `err_pulse` is registered. It is high for exactly the cycle after the offending accept.
- **Reset mid-frame or in HOLD:** asynchronous clear to the reset values. Partial data is lost, and no counters change other than being cleared.
- **`in_valid` while `in_ready`=0:** ignored. The upstream must hold the sample until `in_ready` returns.

## Structure
- **Shared package `tnn_pkg`:** the state enum (GET_A, GET_B, GET_C, HOLD) and `localparam FEAT_W = 3`. The package is reused by the downstream neuron-array wrappers.
- **Sub-module `tnn_quant3`:** purely combinational, parameterised by DATA_W, OFFSET and SHIFT; produces `q[2:0]`. It is instantiated once and also reused by the offline reference model.
- **Top level:** holds the FSM, the shadow and output registers, and the counters.

## Test plan
Use DATA_W=8, OFFSET=16, SHIFT=4 unless stated otherwise.
- **Quantization:** samples 10, 40, 200 with `in_last` on 200 → feat_a=0, feat_b=1, feat_c=7; `out_valid` high the cycle after the third accept; `frame_cnt`=1 after `out_ready`.
- **Backpressure:** keep `out_ready`=0 for 5 cycles while `in_valid`=1 → `in_ready`=0 throughout, feat_* unchanged; release → next sample accepted one edge later.
- **Short frame:** `in_last` on the 2nd sample → `err_pulse` for one cycle, `err_cnt`=1, no `out_valid`; the next 3-sample frame is delivered correctly.
- **Long frame:** 3rd sample without `in_last` → error; the 4th sample becomes feature a of a new frame.
- **Async reset in HOLD:** assert `rst_n`=0 mid-cycle → `out_valid`, feat_* and counters are 0 immediately; after release a full frame works.
- **Counter limits:** with CNT_W=2, 5 delivered frames → `frame_cnt`=1 (wrap); 5 short frames → `err_cnt`=3 (saturate).

Source files
------------

// File: rtl/tnn_pkg.sv
// Shared definitions for the TNN feature framer and the downstream neuron-array wrappers.
package tnn_pkg;

   localparam int FEAT_W = 3;

   typedef logic [1:0] state_t;

   // Kept as plain constants so older wrappers can compare against raw codes.
   localparam state_t GET_A = 2'd0;
   localparam state_t GET_B = 2'd1;
   localparam state_t GET_C = 2'd2;
   localparam state_t HOLD  = 2'd3;

endpackage

// File: rtl/tnn_quant3.sv
// Combinational 3-bit quantizer: subtract an offset (clamped at zero), shift, saturate to 7.
module tnn_quant3
   import tnn_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OFFSET = 0,
   parameter int SHIFT  = 5
) (
   input  logic [DATA_W-1:0] data,
   output logic [FEAT_W-1:0] q
);

   localparam logic [DATA_W-1:0] OFF = DATA_W'(OFFSET);
   localparam logic [DATA_W-1:0] MAXQ = DATA_W'(7);

   logic [DATA_W-1:0] diff;
   logic [DATA_W-1:0] shifted;

   always_comb begin
      diff    = (data > OFF) ? (data - OFF) : '0;
      shifted = diff >> SHIFT;
      q       = (shifted > MAXQ) ? 3'd7 : shifted[FEAT_W-1:0];
   end

endmodule

// File: rtl/tnn_feature_framer.sv
// Groups three quantized samples into a frame and holds it stable for the neuron until consumed.
module tnn_feature_framer
   import tnn_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OFFSET = 0,
   parameter int SHIFT  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [FEAT_W-1:0] feat_a,
   output logic [FEAT_W-1:0] feat_b,
   output logic [FEAT_W-1:0] feat_c,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              err_pulse,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   state_t            state;
   logic [FEAT_W-1:0] q;
   logic [FEAT_W-1:0] a_shadow;
   logic [FEAT_W-1:0] b_shadow;
   logic              accept;
   logic              err_now;

   tnn_quant3 #(
      .DATA_W (DATA_W),
      .OFFSET (OFFSET),
      .SHIFT  (SHIFT)
   ) u_quant (
      .data (in_data),
      .q    (q)
   );

   // Gating with rst_n keeps in_ready low for the whole reset period.
   assign in_ready = rst_n & (state != HOLD);
   assign accept   = in_valid & in_ready;
   assign err_now  = accept & (((state == GET_A || state == GET_B) && in_last) ||
                               ((state == GET_C) && !in_last));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= GET_A;
         a_shadow  <= '0;
         b_shadow  <= '0;
         feat_a    <= '0;
         feat_b    <= '0;
         feat_c    <= '0;
         out_valid <= 1'b0;
         frame_cnt <= '0;
      end else begin
         case (state)
            GET_A: if (accept) begin
               a_shadow <= q;
               state    <= in_last ? GET_A : GET_B;
            end
            GET_B: if (accept) begin
               b_shadow <= q;
               state    <= in_last ? GET_A : GET_C;
            end
            GET_C: if (accept) begin
               if (in_last) begin
                  feat_a    <= a_shadow;
                  feat_b    <= b_shadow;
                  feat_c    <= q;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end else begin
                  state <= GET_A;
               end
            end
            default: if (out_valid && out_ready) begin
               out_valid <= 1'b0;
               frame_cnt <= frame_cnt + 1'b1;
               state     <= GET_A;
            end
         endcase
      end
   end

   // Error counter saturates so a flood of bad frames stays visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pulse <= 1'b0;
         err_cnt   <= '0;
      end else begin
         err_pulse <= err_now;
         if (err_now && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tnn_feature_framer.sv
// Directed scoreboard bench for tnn_feature_framer; a second narrow-counter instance shares the stimulus.
module tb_tnn_feature_framer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_valid;
   logic       out_ready;

   logic        in_ready, out_valid, err_pulse;
   logic [2:0]  feat_a, feat_b, feat_c;
   logic [15:0] frame_cnt, err_cnt;

   logic        in_ready2, out_valid2, err_pulse2;
   logic [2:0]  feat_a2, feat_b2, feat_c2;
   logic [1:0]  frame_cnt2, err_cnt2;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   tnn_feature_framer #(.DATA_W(8), .OFFSET(16), .SHIFT(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready), .feat_a(feat_a), .feat_b(feat_b),
      .feat_c(feat_c), .out_valid(out_valid), .out_ready(out_ready),
      .err_pulse(err_pulse), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );

   tnn_feature_framer #(.DATA_W(8), .OFFSET(16), .SHIFT(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready2), .feat_a(feat_a2), .feat_b(feat_b2),
      .feat_c(feat_c2), .out_valid(out_valid2), .out_ready(out_ready),
      .err_pulse(err_pulse2), .frame_cnt(frame_cnt2), .err_cnt(err_cnt2)
   );

   function automatic logic [2:0] quant(input int x);
      int d;
      d = (x > 16) ? x - 16 : 0;
      d = d >> 4;
      return (d > 7) ? 3'd7 : d[2:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present one sample at a negedge and return at the negedge after it is accepted.
   task automatic send(input int data, input logic last);
      int n = 0;
      in_data  = 8'(data);
      in_last  = last;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("in_ready_timeout", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_frame(input int a, input int b, input int c);
      exp_q.push_back({quant(a), quant(b), quant(c)});
      send(a, 1'b0);
      send(b, 1'b0);
      send(c, 1'b1);
   endtask

   task automatic expect_frame(input string tag);
      int n = 0;
      logic [8:0] e;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, out_valid, 1);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, exp_q.size(), 1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_a"}, feat_a, e[8:6]);
         check({tag, "_b"}, feat_b, e[5:3]);
         check({tag, "_c"}, feat_c, e[2:0]);
      end
   endtask

   task automatic release_frame();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [8:0] held;
      rst_n = 1'b0; in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_feats", {feat_a, feat_b, feat_c}, 0);
      check("rst_err_pulse", err_pulse, 0);
      check("rst_counters", {frame_cnt, err_cnt}, 0);
      rst_n = 1'b1;
      #1 check("rel_in_ready", in_ready, 1);
      @(negedge clk);

      // Quantization and latency
      send_frame(10, 40, 200);
      check("lat_out_valid", out_valid, 1);
      check("lat_in_ready", in_ready, 0);
      expect_frame("quant");
      check("quant_known_a", feat_a, 0);
      check("quant_known_c", feat_c, 7);
      release_frame();
      check("quant_frame_cnt", frame_cnt, 1);
      check("quant_released", out_valid, 0);

      // Backpressure
      send_frame(45, 100, 130);
      expect_frame("bp");
      held = {feat_a, feat_b, feat_c};
      in_data = 8'd50; in_valid = 1'b1; in_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_in_ready", in_ready, 0);
         check("bp_feats_stable", {feat_a, feat_b, feat_c}, held);
      end
      release_frame();
      check("bp_ready_after_release", in_ready, 1);
      check("bp_frame_cnt", frame_cnt, 2);
      send_frame(50, 60, 70);
      expect_frame("bp_next");
      release_frame();

      // Short frame
      send(20, 1'b0);
      send(100, 1'b1);
      check("short_err_pulse", err_pulse, 1);
      check("short_err_cnt", err_cnt, 1);
      check("short_no_valid", out_valid, 0);
      @(negedge clk);
      check("short_pulse_width", err_pulse, 0);
      send_frame(30, 90, 250);
      expect_frame("after_short");
      release_frame();

      // Long frame: fourth sample starts a new frame
      send(1, 1'b0);
      send(2, 1'b0);
      send(3, 1'b0);
      check("long_err_pulse", err_pulse, 1);
      check("long_err_cnt", err_cnt, 2);
      send_frame(255, 33, 48);
      expect_frame("after_long");
      release_frame();
      check("long_frame_cnt", frame_cnt, 5);

      // Asynchronous reset while holding a frame
      send(120, 1'b0);
      send(140, 1'b0);
      send(160, 1'b1);
      check("hold_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_feats", {feat_a, feat_b, feat_c}, 0);
      check("arst_counters", {frame_cnt, err_cnt}, 0);
      check("arst_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(17, 64, 111);
      expect_frame("after_arst");
      release_frame();
      check("arst_frame_cnt", frame_cnt, 1);

      // Counter wrap and saturation on the narrow instance
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         send_frame(20 + i * 30, 200 - i * 25, 80 + i * 7);
         expect_frame("cnt_frame");
         release_frame();
      end
      check("wrap_frame_cnt2", frame_cnt2, 1);
      check("wide_frame_cnt", frame_cnt, 5);
      for (int i = 0; i < 5; i++) send(i * 40, 1'b1);
      @(negedge clk);
      check("sat_err_cnt2", err_cnt2, 3);
      check("wide_err_cnt", err_cnt, 5);
      check("sb_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
